// File: rtl/lfsr_run_controller_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_run_controller_pkg
//   Shared definitions for the LFSR run controller slice: controller state
//   encoding, the default feedback tap mask, the command-pulse bundle and the
//   LFSR feedback helper used by lfsr_core.
// ---------------------------------------------------------------------------
package lfsr_run_controller_pkg;

    localparam int unsigned STATE_W = 3;

    // Controller states; encodings are fixed so debug probes read consistently.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_STEP = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } ctrl_state_e;

    // Taps at bits 0, 8, 13 and 31.
    localparam logic [63:0] DEFAULT_TAPS = 64'h0000_0000_8000_2101;

    // One bit per switch command, highest priority first.
    typedef struct packed {
        logic load;
        logic stop;
        logic start;
        logic step;
    } cmd_bus_t;

    // Feedback bit shifted into the MSB: parity of the tapped bits, optionally
    // inverted (XNOR form, whose stuck state is all-ones instead of all-zeros).
    function automatic logic lfsr_feedback(
        input logic [63:0] q,
        input logic [63:0] taps,
        input logic        invert
    );
        return (^(q & taps)) ^ invert;
    endfunction

endpackage

// File: rtl/lfsr_run_controller_core.sv
// ---------------------------------------------------------------------------
// lfsr_core
//   64-bit right-shifting LFSR register. LOAD takes priority over EN.
//   Ports:
//     CLK   clock
//     RST   synchronous active-high reset, clears Q to zero
//     EN    advance one step: Q <= {fb, Q[63:1]}
//     LOAD  load D into Q
//     D     parallel load value
//     Q     current LFSR state (registered)
// ---------------------------------------------------------------------------
module lfsr_core
    import lfsr_run_controller_pkg::*;
#(
    parameter logic [63:0] TAPS   = DEFAULT_TAPS,
    parameter bit          INVERT = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        LOAD,
    input  logic [63:0] D,
    output logic [63:0] Q
);

    logic [63:0] q_q;
    logic [63:0] q_d;

    // Next LFSR value: load, shift, or hold.
    always_comb begin
        q_d = q_q;
        if (LOAD) begin
            q_d = D;
        end else if (EN) begin
            q_d = {lfsr_feedback(q_q, TAPS, INVERT), q_q[63:1]};
        end else begin
            q_d = q_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_q <= 64'h0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/lfsr_run_controller.sv
// ---------------------------------------------------------------------------
// lfsr_run_controller
//   Sequencer for a 64-bit LFSR driven from slow level-type switches.
//   Rising edges of the command switches become single-cycle actions:
//   load seed, single step, run RUN_LEN steps (0 = until stopped), stop.
//   Ports:
//     CLK, RST     clock, synchronous active-high reset
//     CMD_LOAD     rising edge loads SEED (next cycle)
//     CMD_START    rising edge starts a run, clearing STEP_COUNT
//     CMD_STOP     rising edge aborts a run / leaves DONE
//     CMD_STEP     rising edge advances exactly one step (next cycle)
//     RUN_LEN      steps per run, 0 = free-run
//     SEED         value loaded on CMD_LOAD
//     LFSR_OUT     LFSR state
//     STEP_COUNT   advances since last load/start (wraps)
//     BUSY         run in progress
//     DONE         run finished, state held
//     LOCKUP       LFSR_OUT is all-ones (XNOR stuck state)
// ---------------------------------------------------------------------------
module lfsr_run_controller
    import lfsr_run_controller_pkg::*;
#(
    parameter int unsigned CNT_W  = 16,
    parameter logic [63:0] TAPS   = DEFAULT_TAPS,
    parameter bit          INVERT = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_LOAD,
    input  logic             CMD_START,
    input  logic             CMD_STOP,
    input  logic             CMD_STEP,
    input  logic [CNT_W-1:0] RUN_LEN,
    input  logic [63:0]      SEED,
    output logic [63:0]      LFSR_OUT,
    output logic [CNT_W-1:0] STEP_COUNT,
    output logic             BUSY,
    output logic             DONE,
    output logic             LOCKUP
);

    cmd_bus_t         cmd_now_s;
    cmd_bus_t         cmd_prev_q;
    cmd_bus_t         pulse_raw_s;
    cmd_bus_t         pulse_sel_s;
    ctrl_state_e      state_q;
    ctrl_state_e      state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             busy_q;
    logic             done_q;
    logic             core_en_s;
    logic             core_load_s;
    logic             cnt_clr_s;
    logic             run_last_s;
    logic [63:0]      lfsr_s;

    assign cmd_now_s   = '{load: CMD_LOAD, stop: CMD_STOP, start: CMD_START, step: CMD_STEP};
    assign pulse_raw_s = cmd_now_s & ~cmd_prev_q;

    // Switch history. Loaded during reset as well, so a switch held high
    // through reset does not look like a fresh edge afterwards.
    always_ff @(posedge CLK) begin
        cmd_prev_q <= cmd_now_s;
    end

    // Keep only the highest-priority pulse: LOAD > STOP > START > STEP.
    always_comb begin
        pulse_sel_s = '0;
        if (pulse_raw_s.load) begin
            pulse_sel_s.load = 1'b1;
        end else if (pulse_raw_s.stop) begin
            pulse_sel_s.stop = 1'b1;
        end else if (pulse_raw_s.start) begin
            pulse_sel_s.start = 1'b1;
        end else if (pulse_raw_s.step) begin
            pulse_sel_s.step = 1'b1;
        end else begin
            pulse_sel_s = '0;
        end
    end

    // Last step of a bounded run: the count before this advance is RUN_LEN-1.
    assign run_last_s = (RUN_LEN != {CNT_W{1'b0}}) && (cnt_q == (RUN_LEN - CNT_W'(1)));

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // STOP wins over START/STEP here but has nothing to stop.
                if (pulse_sel_s.load) begin
                    state_d = ST_LOAD;
                end else if (pulse_sel_s.start) begin
                    state_d = ST_RUN;
                end else if (pulse_sel_s.step) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            ST_STEP: state_d = ST_IDLE;
            ST_RUN: begin
                if (pulse_sel_s.load) begin
                    state_d = ST_LOAD;
                end else if (pulse_sel_s.stop) begin
                    state_d = ST_IDLE;
                end else if (run_last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (pulse_sel_s.load) begin
                    state_d = ST_LOAD;
                end else if (pulse_sel_s.stop) begin
                    state_d = ST_IDLE;
                end else if (pulse_sel_s.start) begin
                    state_d = ST_RUN;
                end else if (pulse_sel_s.step) begin
                    state_d = ST_STEP;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM datapath controls.
    always_comb begin
        core_load_s = 1'b0;
        core_en_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        case (state_q)
            ST_IDLE: cnt_clr_s = pulse_sel_s.start;
            ST_LOAD: begin
                core_load_s = 1'b1;
                cnt_clr_s   = 1'b1;
            end
            ST_STEP: core_en_s = 1'b1;
            // A LOAD or STOP seen in RUN suppresses that cycle's advance.
            ST_RUN:  core_en_s = ~(pulse_sel_s.load | pulse_sel_s.stop);
            ST_DONE: cnt_clr_s = pulse_sel_s.start;
            default: begin
                core_load_s = 1'b0;
                core_en_s   = 1'b0;
                cnt_clr_s   = 1'b0;
            end
        endcase
    end

    // Step counter next value.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (core_en_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Step counter and status flags, registered from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (state_d == ST_RUN);
            done_q <= (state_d == ST_DONE);
        end
    end

    lfsr_core #(
        .TAPS   (TAPS),
        .INVERT (INVERT)
    ) u_core (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (core_en_s),
        .LOAD (core_load_s),
        .D    (SEED),
        .Q    (lfsr_s)
    );

    assign LFSR_OUT   = lfsr_s;
    assign STEP_COUNT = cnt_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign LOCKUP     = &lfsr_s;

endmodule

// File: tb/tb_lfsr_run_controller.sv
// ---------------------------------------------------------------------------
// tb_lfsr_run_controller
//   Each clock the stimulus thread advances a behavioural reference model
//   and queues the expected outputs; a monitor on the falling edge pops and
//   compares. Directed scenarios add checks against fixed constants, then a
//   randomized phase exercises command mixes and resets.
// ---------------------------------------------------------------------------
module tb_lfsr_run_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_LOAD, CMD_START, CMD_STOP, CMD_STEP;
    logic [15:0] RUN_LEN;
    logic [63:0] SEED;
    logic [63:0] LFSR_OUT;
    logic [15:0] STEP_COUNT;
    logic        BUSY, DONE, LOCKUP;

    always #5 CLK = ~CLK;

    lfsr_run_controller #(
        .CNT_W  (16),
        .TAPS   (64'h0000_0000_8000_2101),
        .INVERT (1'b1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CMD_LOAD   (CMD_LOAD),
        .CMD_START  (CMD_START),
        .CMD_STOP   (CMD_STOP),
        .CMD_STEP   (CMD_STEP),
        .RUN_LEN    (RUN_LEN),
        .SEED       (SEED),
        .LFSR_OUT   (LFSR_OUT),
        .STEP_COUNT (STEP_COUNT),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .LOCKUP     (LOCKUP)
    );

    typedef struct {
        logic [63:0] q;
        logic [15:0] cnt;
        logic        busy;
        logic        done;
        logic        lockup;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: pending one-cycle actions, a running flag and the
    // number of steps left in a bounded run (0 = unbounded).
    logic [63:0] m_q;
    logic [15:0] m_cnt;
    bit          m_busy, m_done, m_loadp, m_stepp;
    int          m_left;
    logic [3:0]  m_prev;

    function automatic logic [63:0] ref_next(input logic [63:0] v);
        int   taps[4];
        logic fb;
        taps = '{0, 8, 13, 31};
        fb   = 1'b1;
        foreach (taps[i]) fb = fb ^ v[taps[i]];
        return {fb, v[63:1]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic model_advance();
        m_q   = ref_next(m_q);
        m_cnt = m_cnt + 16'd1;
    endtask

    // One clock of the reference model using the inputs currently driven.
    task automatic model_step();
        logic [3:0] cmd;
        logic [3:0] p;
        cmd = {CMD_LOAD, CMD_STOP, CMD_START, CMD_STEP};
        if (RST) begin
            m_q = 64'h0; m_cnt = 16'h0; m_busy = 0; m_done = 0;
            m_loadp = 0; m_stepp = 0; m_left = 0; m_prev = cmd;
            return;
        end
        p      = cmd & ~m_prev;
        m_prev = cmd;
        if (m_loadp) begin
            m_q = SEED; m_cnt = 16'h0; m_loadp = 0;
        end else if (m_stepp) begin
            model_advance(); m_stepp = 0;
        end else if (m_busy) begin
            if (p[3]) begin
                m_busy = 0; m_loadp = 1;
            end else if (p[2]) begin
                m_busy = 0;
            end else begin
                model_advance();
                if (m_left != 0) begin
                    m_left--;
                    if (m_left == 0) begin m_busy = 0; m_done = 1; end
                end
            end
        end else begin
            if (p[3]) begin
                m_loadp = 1; m_done = 0;
            end else if (p[2]) begin
                m_done = 0;
            end else if (p[1]) begin
                m_busy = 1; m_done = 0; m_cnt = 16'h0; m_left = int'(RUN_LEN);
            end else if (p[0]) begin
                m_stepp = 1; m_done = 0;
            end
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge CLK);
        e.q = m_q; e.cnt = m_cnt; e.busy = m_busy; e.done = m_done; e.lockup = (m_q == 64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Scoreboard monitor: compares on every falling edge with a pending entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_lfsr",   LFSR_OUT,   e.q);
                check("sb_count",  64'(STEP_COUNT), 64'(e.cnt));
                check("sb_busy",   64'(BUSY),   64'(e.busy));
                check("sb_done",   64'(DONE),   64'(e.done));
                check("sb_lockup", 64'(LOCKUP), 64'(e.lockup));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          busy_cycles;
        logic [63:0] snap;
        RST = 1'b1; CMD_LOAD = 1'b0; CMD_STOP = 1'b0; CMD_STEP = 1'b0;
        CMD_START = 1'b1; RUN_LEN = 16'd0; SEED = 64'h0;

        // Reset with START held high: no run afterwards.
        ticks(3);
        RST = 1'b0;
        ticks(5);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_done", 64'(DONE), 64'd0);
        check("rst_lfsr", LFSR_OUT, 64'h0);
        CMD_START = 1'b0;
        tick();

        // Single steps from reset.
        CMD_STEP = 1'b1; ticks(2);
        check("step1_lfsr",  LFSR_OUT, 64'h8000_0000_0000_0000);
        check("step1_count", 64'(STEP_COUNT), 64'd1);
        CMD_STEP = 1'b0; tick();
        CMD_STEP = 1'b1; ticks(2);
        check("step2_lfsr",  LFSR_OUT, 64'hC000_0000_0000_0000);
        check("step2_count", 64'(STEP_COUNT), 64'd2);
        CMD_STEP = 1'b0; tick();

        // Bounded run of 3 from reset.
        RST = 1'b1; tick(); RST = 1'b0; tick();
        RUN_LEN = 16'd3; CMD_START = 1'b1; tick(); CMD_START = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (DONE) break;
            if (BUSY) busy_cycles++;
            tick();
        end
        check("run3_busy_cycles", 64'(busy_cycles), 64'd3);
        check("run3_lfsr",  LFSR_OUT, 64'hE000_0000_0000_0000);
        check("run3_count", 64'(STEP_COUNT), 64'd3);
        check("run3_done",  64'(DONE), 64'd1);

        // All-ones seed is the XNOR lockup state; a run leaves it unchanged.
        SEED = 64'hFFFF_FFFF_FFFF_FFFF; CMD_LOAD = 1'b1; ticks(2);
        check("lock_flag", 64'(LOCKUP), 64'd1);
        CMD_LOAD = 1'b0; RUN_LEN = 16'd5; CMD_START = 1'b1; tick(); CMD_START = 1'b0;
        ticks(6);
        check("lock_lfsr",  LFSR_OUT, 64'hFFFF_FFFF_FFFF_FFFF);
        check("lock_count", 64'(STEP_COUNT), 64'd5);
        check("lock_done",  64'(DONE), 64'd1);

        // Free run stopped after 10 advances.
        SEED = 64'h0123_4567_89AB_CDEF; CMD_LOAD = 1'b1; ticks(2); CMD_LOAD = 1'b0;
        RUN_LEN = 16'd0; CMD_START = 1'b1; tick(); CMD_START = 1'b0;
        ticks(10);
        snap = LFSR_OUT;
        CMD_STOP = 1'b1; tick(); CMD_STOP = 1'b0;
        check("stop_count", 64'(STEP_COUNT), 64'd10);
        check("stop_busy",  64'(BUSY), 64'd0);
        check("stop_lfsr",  LFSR_OUT, snap);

        // LOAD and START together during a run: LOAD wins.
        CMD_START = 1'b1; tick(); CMD_START = 1'b0; ticks(4);
        SEED = 64'hDEAD_BEEF_0BAD_F00D; CMD_LOAD = 1'b1; CMD_START = 1'b1;
        ticks(2);
        check("ls_lfsr",  LFSR_OUT, 64'hDEAD_BEEF_0BAD_F00D);
        check("ls_count", 64'(STEP_COUNT), 64'd0);
        check("ls_busy",  64'(BUSY), 64'd0);
        ticks(3);
        check("ls_no_run", 64'(BUSY), 64'd0);
        CMD_LOAD = 1'b0; CMD_START = 1'b0; tick();

        // Randomized command mix; RUN_LEN only changes outside runs.
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 11) == 0) CMD_LOAD  = ~CMD_LOAD;
            if ($urandom_range(0, 9)  == 0) CMD_STOP  = ~CMD_STOP;
            if ($urandom_range(0, 3)  == 0) CMD_START = ~CMD_START;
            if ($urandom_range(0, 3)  == 0) CMD_STEP  = ~CMD_STEP;
            if ($urandom_range(0, 7)  == 0) SEED = {$urandom(), $urandom()};
            if (!m_busy && $urandom_range(0, 3) == 0) RUN_LEN = 16'($urandom_range(0, 12));
            tick();
        end
        RST = 1'b0;

        repeat (2) @(negedge CLK);
        #1;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
